data_memory_ctrl: RTL

//  - Parametrised data memory for the datapath MEM stage; successor of the fixed 256-word array.
//  - Accepts one request at a time over a valid/ready handshake, with a configurable number of wait states.
//  - Supports byte, halfword and word stores using byte-lane merge.
//  - Loads are sign- or zero-extended.
//  - Alignment and range violations are reported on resp_err.
//  - Reset clears the array with a sequential sweep, one word per cycle.

---
 rtl/data_memory_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// Data memory for the MEM stage: valid/ready requests, wait states,
// byte-lane stores, extended loads, reset-time clear sweep.
module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CLEAR, IDLE, WAIT, ACCESS, RESP
  } state_t;

  state_t        state;
  logic [AW-1:0] clear_idx;
  logic [3:0]    cnt;

  logic          wr_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic          req_err;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    lo8;
  logic [15:0]   lo16;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   merged;

  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      req_size == 2'b00: req_err = 1'b0;
      req_size == 2'b01: req_err = req_addr[0];
      req_size == 2'b10: req_err = |req_addr[1:0];
      req_size == 2'b11: req_err = 1'b1;
      default:           req_err = 1'b1;
    endcase
    if (|req_addr[31:AW+2]) req_err = 1'b1;
  end

  assign widx  = addr_q[AW+1:2];
  assign rword = mem[widx];
  assign lo8   = rword[{addr_q[1:0], 3'b000} +: 8];
  assign lo16  = rword[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rword;
    be       = 4'b1111;
    wlane    = wdata_q;
    unique case (1'b1)
      size_q == 2'b00: begin
        load_val = uns_q ? {24'b0, lo8}
                         : {{24{lo8[7]}}, lo8};
        be       = 4'b0001 << addr_q[1:0];
        wlane    = {4{wdata_q[7:0]}};
      end
      size_q == 2'b01: begin
        load_val = uns_q ? {16'b0, lo16}
                         : {{16{lo16[15]}}, lo16};
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata_q[15:0]}};
      end
      default: begin
        load_val = rword;
        be       = 4'b1111;
        wlane    = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = be[i] ? wlane[8*i +: 8]
                               : rword[8*i +: 8];
  end

  // Single write port shared by the clear sweep and stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clear_idx] <= '0;
      else if (state == ACCESS && wr_q)
        mem[widx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clear_idx  <= '0;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == AW'(DEPTH - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr_q      <= req_write;
            addr_q    <= req_addr[AW+1:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= wr_q ? 32'h0 : load_val;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
